// File: rtl/taxi_fare_acc.sv
// Fare accumulator for the taximeter.
// Counts distance pulses into a 3-digit BCD fare in 100-won units (000..999),
// tracks the trip mode (normal/premium), and holds the final fare until the
// receipt handshake (ack) releases it.
module taxi_fare_acc #(
  parameter int unsigned BASE_N = 38,  // normal base fare, 100-won units
  parameter int unsigned BASE_P = 50,  // premium base fare, 100-won units
  parameter int unsigned STEP_N = 1,   // per-pulse increment, normal
  parameter int unsigned STEP_P = 2    // per-pulse increment, premium
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       normal,
  input  logic       premium,
  input  logic       stop,
  input  logic       meter,
  input  logic       ack,
  output logic [3:0] fare_d0,
  output logic [3:0] fare_d1,
  output logic [3:0] fare_d2,
  output logic       running,
  output logic       prem_mode,
  output logic       done,
  output logic       sat,
  output logic [9:0] tick_cnt
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRunN = 2'd1;
  localparam logic [1:0] StRunP = 2'd2;
  localparam logic [1:0] StHold = 2'd3;

  localparam logic [9:0] CntMax = 10'h3ff;

  // Elaboration-time binary to 3-digit BCD conversion of the base fares.
  function automatic logic [11:0] to_bcd(input int unsigned v);
    logic [11:0] r;
    r[11:8] = 4'((v / 100) % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  localparam logic [11:0] BaseNBcd = to_bcd(BASE_N);
  localparam logic [11:0] BasePBcd = to_bcd(BASE_P);
  localparam logic [3:0]  StepN    = 4'(STEP_N);
  localparam logic [3:0]  StepP    = 4'(STEP_P);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic       m1_q, m2_q, m3_q;
  logic [1:0] state_q, state_d;
  logic [3:0] d0_q, d0_d;
  logic [3:0] d1_q, d1_d;
  logic [3:0] d2_q, d2_d;
  logic       sat_q, sat_d;
  logic [9:0] cnt_q, cnt_d;

  // ---------------------------------------------------------------------------
  // Distance pulse synchronizer and rising-edge detect
  // ---------------------------------------------------------------------------
  logic tick;

  // Three-stage meter synchronizer; m3 only serves the edge detector.
  always_ff @(posedge clk) begin
    if (reset) begin
      m1_q <= 1'b0;
      m2_q <= 1'b0;
      m3_q <= 1'b0;
    end else begin
      m1_q <= meter;
      m2_q <= m1_q;
      m3_q <= m2_q;
    end
  end

  // A level already high on entry to RUN is not an edge, so it never ticks.
  assign tick = m2_q & ~m3_q;

  // ---------------------------------------------------------------------------
  // BCD increment by the current mode's step, with saturation at 999
  // ---------------------------------------------------------------------------
  logic [3:0] step_sel;
  logic [4:0] sum0, sum1, sum2;
  logic       c0, c1, c2;
  logic [3:0] add0, add1, add2;

  // Ripple decimal add; a carry out of the top digit means the fare passed 999.
  always_comb begin
    step_sel = (state_q == StRunP) ? StepP : StepN;

    sum0 = 5'(d0_q) + 5'(step_sel);
    c0   = (sum0 > 5'd9);
    add0 = c0 ? 4'(sum0 - 5'd10) : sum0[3:0];

    sum1 = 5'(d1_q) + 5'(c0);
    c1   = (sum1 > 5'd9);
    add1 = c1 ? 4'(sum1 - 5'd10) : sum1[3:0];

    sum2 = 5'(d2_q) + 5'(c1);
    c2   = (sum2 > 5'd9);
    add2 = c2 ? 4'(sum2 - 5'd10) : sum2[3:0];
  end

  // ---------------------------------------------------------------------------
  // Trip FSM and fare datapath next-state
  // ---------------------------------------------------------------------------
  // Next state, fare, saturation flag and pulse count for the current cycle.
  always_comb begin
    state_d = state_q;
    d0_d    = d0_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    sat_d   = sat_q;
    cnt_d   = cnt_q;

    case (state_q)
      StIdle: begin
        if (normal) begin
          state_d            = StRunN;
          {d2_d, d1_d, d0_d} = BaseNBcd;
          sat_d              = 1'b0;
          cnt_d              = '0;
        end else if (premium) begin
          state_d            = StRunP;
          {d2_d, d1_d, d0_d} = BasePBcd;
          sat_d              = 1'b0;
          cnt_d              = '0;
        end
      end

      StRunN, StRunP: begin
        // The tick uses the step of the state we are leaving, even when this
        // same cycle switches rate or ends the trip.
        if (tick) begin
          if (c2) begin
            {d2_d, d1_d, d0_d} = {4'd9, 4'd9, 4'd9};
            sat_d              = 1'b1;
          end else begin
            {d2_d, d1_d, d0_d} = {add2, add1, add0};
          end
          if (cnt_q != CntMax) begin
            cnt_d = cnt_q + 10'd1;
          end
        end

        if (stop) begin
          state_d = StHold;
        end else if (normal) begin
          state_d = StRunN;
        end else if (premium) begin
          state_d = StRunP;
        end
      end

      StHold: begin
        // sat survives the receipt; it clears only at the next trip start.
        if (ack) begin
          state_d            = StIdle;
          {d2_d, d1_d, d0_d} = 12'h000;
          cnt_d              = '0;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      d0_q    <= 4'd0;
      d1_q    <= 4'd0;
      d2_q    <= 4'd0;
      sat_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      sat_q   <= sat_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Status flags decode the registered state directly.
  always_comb begin
    fare_d0   = d0_q;
    fare_d1   = d1_q;
    fare_d2   = d2_q;
    running   = (state_q == StRunN) || (state_q == StRunP);
    prem_mode = (state_q == StRunP);
    done      = (state_q == StHold);
    sat       = sat_q;
    tick_cnt  = cnt_q;
  end

endmodule
